// File: rtl/store_buf_pkg.sv
// Shared entry layout, width codes and default depth for the posted-store buffer.
// Width codes mirror the CPU-wide definitions; the buffer only carries them through.
`ifndef SB_DEPTH
`define SB_DEPTH 4
`endif

package store_buf_pkg;

   localparam int SB_DEPTH_DEF = `SB_DEPTH;

   localparam logic [2:0] OP_WD = 3'd0;
   localparam logic [2:0] OP_HF = 3'd1;
   localparam logic [2:0] OP_BT = 3'd2;

   typedef struct packed {
      logic [31:0] ax;
      logic [31:0] x;
      logic [2:0]  op;
      logic [31:0] pc;
   } entry_t;

endpackage

// File: rtl/store_buf.sv
// Posted-store FIFO in front of dm: accepted stores drain in order one edge later at the earliest,
// st_full holds the CPU when DEPTH stores are pending, and loads hitting a pending word are stalled.
module store_buf
   import store_buf_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH_DEF,
   parameter int PW    = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        st_en,
   input  logic [31:0] st_ax,
   input  logic [31:0] st_x,
   input  logic [2:0]  st_op,
   input  logic [31:0] st_pc,
   output logic        st_full,
   input  logic        ld_en,
   input  logic [31:0] ld_ax,
   output logic        ld_stall,
   input  logic        dm_busy,
   output logic        dm_en,
   output logic [31:0] dm_ax,
   output logic [31:0] dm_x,
   output logic [2:0]  dm_op,
   output logic [31:0] dm_pcw,
   output logic        empty
);

   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   entry_t           ent_q [DEPTH];
   logic [DEPTH-1:0] vld_q, vld_d;
   logic [PW-1:0]    head_q, head_d;
   logic [PW-1:0]    tail_q, tail_d;
   logic [PW:0]      cnt_q, cnt_d;
   logic             enq, deq;
   entry_t           head_ent;
   logic [DEPTH-1:0] hit;
   logic             unused_ld;

   assign st_full  = (cnt_q == FULL_CNT);
   assign empty    = (cnt_q == '0);
   assign enq      = st_en && !st_full;
   assign dm_en    = !empty && !dm_busy;
   assign deq      = dm_en;

   assign head_ent = empty ? '0 : ent_q[head_q];
   assign dm_ax    = head_ent.ax;
   assign dm_x     = head_ent.x;
   assign dm_op    = head_ent.op;
   assign dm_pcw   = head_ent.pc;

   // Word compare over the 4 KiB window dm aliases into; byte lanes are ignored.
   for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
      assign hit[g] = vld_q[g] && (ent_q[g].ax[11:2] == ld_ax[11:2]);
   end
   assign ld_stall  = ld_en && (|hit);
   assign unused_ld = ^{ld_ax[31:12], ld_ax[1:0]};

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      vld_d  = vld_q;
      if (enq) begin
         vld_d[tail_q] = 1'b1;
         tail_d        = tail_q + PW'(1);
      end
      if (deq) begin
         vld_d[head_q] = 1'b0;
         head_d        = head_q + PW'(1);
      end
      case ({enq, deq})
         2'b10:   cnt_d = cnt_q + (PW+1)'(1);
         2'b01:   cnt_d = cnt_q - (PW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
         vld_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
         vld_q  <= vld_d;
      end
   end

   // Payload needs no reset: it is only observed through valid bits and the count.
   always_ff @(posedge clk) begin
      if (enq) begin
         ent_q[tail_q] <= '{ax: st_ax, x: st_x, op: st_op, pc: st_pc};
      end
   end

endmodule

// File: tb/tb_store_buf.sv
// Directed bench for store_buf with a drain-order scoreboard.
module tb_store_buf;
   import store_buf_pkg::*;

   logic        clk;
   logic        rst;
   logic        st_en;
   logic [31:0] st_ax;
   logic [31:0] st_x;
   logic [2:0]  st_op;
   logic [31:0] st_pc;
   logic        st_full;
   logic        ld_en;
   logic [31:0] ld_ax;
   logic        ld_stall;
   logic        dm_busy;
   logic        dm_en;
   logic [31:0] dm_ax;
   logic [31:0] dm_x;
   logic [2:0]  dm_op;
   logic [31:0] dm_pcw;
   logic        empty;

   int checks = 0;
   int errors = 0;
   entry_t sb_q[$];

   store_buf dut (
      .clk      (clk),
      .rst      (rst),
      .st_en    (st_en),
      .st_ax    (st_ax),
      .st_x     (st_x),
      .st_op    (st_op),
      .st_pc    (st_pc),
      .st_full  (st_full),
      .ld_en    (ld_en),
      .ld_ax    (ld_ax),
      .ld_stall (ld_stall),
      .dm_busy  (dm_busy),
      .dm_en    (dm_en),
      .dm_ax    (dm_ax),
      .dm_x     (dm_x),
      .dm_op    (dm_op),
      .dm_pcw   (dm_pcw),
      .empty    (empty)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_st(input logic en, input logic [31:0] ax, input logic [31:0] x,
                         input logic [2:0] op, input logic [31:0] pc);
      st_en = en;
      st_ax = ax;
      st_x  = x;
      st_op = op;
      st_pc = pc;
   endtask

   // Scoreboard: every drain must match the oldest store still owed; reset forgives the rest.
   always @(negedge clk) begin
      if (dm_en) begin
         if (sb_q.size() == 0) begin
            chk("dm_en_spurious", 128'(dm_en), 128'(1'b0));
         end else begin
            entry_t e;
            e = sb_q.pop_front();
            chk("drain_entry", {dm_ax, dm_x, dm_op, dm_pcw}, {e.ax, e.x, e.op, e.pc});
         end
      end
      if (rst) begin
         sb_q.delete();
      end else if (st_en) begin
         sb_q.push_back('{ax: st_ax, x: st_x, op: st_op, pc: st_pc});
      end
   end

   initial begin
      rst     = 1'b1;
      dm_busy = 1'b0;
      ld_en   = 1'b1;
      ld_ax   = 32'h0;
      set_st(1'b0, 32'h0, 32'h0, OP_WD, 32'h0);

      // Reset
      repeat (2) cyc();
      #1;
      chk("rst_empty", 128'(empty), 128'(1'b1));
      chk("rst_full", 128'(st_full), 128'(1'b0));
      chk("rst_dm_en", 128'(dm_en), 128'(1'b0));
      chk("rst_ld_stall", 128'(ld_stall), 128'(1'b0));
      rst   = 1'b0;
      ld_en = 1'b0;

      // Fill with dm busy, then drain in order
      cyc();
      dm_busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         set_st(1'b1, 32'h10 + 32'(4 * i), 32'hA000 + 32'(i), OP_WD, 32'h400 + 32'(4 * i));
         #1;
         chk("fill_not_full", 128'(st_full), 128'(1'b0));
         chk("fill_busy_no_drain", 128'(dm_en), 128'(1'b0));
         cyc();
      end
      set_st(1'b0, 32'h0, 32'h0, OP_WD, 32'h0);
      #1;
      chk("fill_full", 128'(st_full), 128'(1'b1));
      dm_busy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("drain_en", 128'(dm_en), 128'(1'b1));
         chk("drain_ax", 128'(dm_ax), 128'(32'h10 + 32'(4 * i)));
         chk("drain_full", 128'(st_full), 128'(i == 0));
         cyc();
      end
      #1;
      chk("drain_empty", 128'(empty), 128'(1'b1));
      chk("drain_idle_en", 128'(dm_en), 128'(1'b0));
      chk("drain_idle_ax", 128'(dm_ax), 128'(32'h0));

      // Steady stream: one store per cycle with dm free
      cyc();
      for (int k = 0; k < 6; k++) begin
         set_st(1'b1, 32'h200 + 32'(4 * k), $urandom, OP_WD, 32'h800 + 32'(4 * k));
         #1;
         chk("stream_not_full", 128'(st_full), 128'(1'b0));
         chk("stream_dm_en", 128'(dm_en), 128'(k != 0));
         if (k != 0) chk("stream_dm_ax", 128'(dm_ax), 128'(32'h200 + 32'(4 * (k - 1))));
         cyc();
      end
      set_st(1'b0, 32'h0, 32'h0, OP_WD, 32'h0);
      #1;
      chk("stream_last_en", 128'(dm_en), 128'(1'b1));
      chk("stream_last_ax", 128'(dm_ax), 128'(32'h214));
      cyc();
      #1;
      chk("stream_empty", 128'(empty), 128'(1'b1));

      // Load conflict against a pending word
      cyc();
      dm_busy = 1'b1;
      set_st(1'b1, 32'h1004, 32'hDEADBEEF, OP_WD, 32'hC00);
      cyc();
      set_st(1'b0, 32'h0, 32'h0, OP_WD, 32'h0);
      ld_en = 1'b1;
      ld_ax = 32'h6;
      #1;
      chk("conf_alias", 128'(ld_stall), 128'(1'b1));
      ld_ax = 32'h8;
      #1;
      chk("conf_other_word", 128'(ld_stall), 128'(1'b0));
      ld_ax = 32'h1007;
      #1;
      chk("conf_byte_lane", 128'(ld_stall), 128'(1'b1));
      cyc();
      ld_en = 1'b0;
      ld_ax = 32'h6;
      #1;
      chk("conf_no_load", 128'(ld_stall), 128'(1'b0));
      ld_en   = 1'b1;
      dm_busy = 1'b0;
      #1;
      chk("conf_hold", 128'(ld_stall), 128'(1'b1));
      chk("conf_drain", 128'(dm_en), 128'(1'b1));
      cyc();
      #1;
      chk("conf_clear", 128'(ld_stall), 128'(1'b0));
      chk("conf_empty", 128'(empty), 128'(1'b1));
      ld_en = 1'b0;

      // Byte store passes through unmodified
      cyc();
      dm_busy = 1'b1;
      set_st(1'b1, 32'h3, 32'h123456AB, OP_BT, 32'hF00);
      cyc();
      set_st(1'b0, 32'h0, 32'h0, OP_WD, 32'h0);
      #1;
      chk("bt_busy", 128'(dm_en), 128'(1'b0));
      dm_busy = 1'b0;
      #1;
      chk("bt_en", 128'(dm_en), 128'(1'b1));
      chk("bt_op", 128'(dm_op), 128'(OP_BT));
      chk("bt_ax", 128'(dm_ax), 128'(32'h3));
      chk("bt_x", 128'(dm_x), 128'(32'h123456AB));
      chk("bt_pcw", 128'(dm_pcw), 128'(32'hF00));
      cyc();
      #1;
      chk("bt_empty", 128'(empty), 128'(1'b1));

      // Reset on a drain edge with three pending
      cyc();
      dm_busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_st(1'b1, 32'h500 + 32'(4 * i), 32'hB000 + 32'(i), OP_HF, 32'h900 + 32'(4 * i));
         cyc();
      end
      set_st(1'b0, 32'h0, 32'h0, OP_WD, 32'h0);
      dm_busy = 1'b0;
      rst     = 1'b1;
      #1;
      chk("rstd_drain_en", 128'(dm_en), 128'(1'b1));
      chk("rstd_drain_ax", 128'(dm_ax), 128'(32'h500));
      cyc();
      rst = 1'b0;
      #1;
      chk("rstd_dm_en", 128'(dm_en), 128'(1'b0));
      chk("rstd_empty", 128'(empty), 128'(1'b1));
      for (int i = 0; i < 5; i++) begin
         cyc();
         #1;
         chk("rstd_quiet_en", 128'(dm_en), 128'(1'b0));
         chk("rstd_quiet_empty", 128'(empty), 128'(1'b1));
      end

      chk("sb_drained", 128'(sb_q.size()), 128'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
